// File: rtl/car_sensor_driver.sv
// car_sensor_driver: replays enter/exit Gray sequences on the A/B photo-sensor pair and tracks the expected car count.
// Latency: PH1 on A/B at the accept edge (one edge after the pop with CMD_FIFO_EN); each sequence takes 4*HOLD_CYCLES cycles.
// Backpressure: req_ready is low while a sequence runs, or while the direction FIFO is full when CMD_FIFO_EN is defined.
module car_sensor_driver #(
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 4,
  parameter int MAX_CARS    = 15,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_dir,
  output logic             req_ready,
  output logic             A,
  output logic             B,
  output logic             busy,
  output logic             done,
  output logic             reject,
  output logic [CNT_W-1:0] no_cars
);

  localparam int HC_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CARS_FULL = CNT_W'(MAX_CARS);

  // Illegal parameter sets elaborate this marker block, making them easy to spot in the hierarchy.
  if (HOLD_CYCLES < 1 || MAX_CARS > 2**CNT_W - 1 || FIFO_DEPTH < 1) begin : g_bad_params
  end

  typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP} state_t;

  state_t           state, state_nxt;
  logic [HC_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic             dir_q, dir_nxt;
  logic             a_nxt, b_nxt, done_nxt;
  logic [CNT_W-1:0] no_cars_nxt;
  logic             start, start_dir, refuse;

  // A car may enter only below capacity and leave only when one is present.
  function automatic logic room_for(input logic dir, input logic [CNT_W-1:0] cars);
    return dir ? (cars != CARS_FULL) : (cars != '0);
  endfunction

`ifdef CMD_FIFO_EN
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W:0]   FILL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0] fifo_dir;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        fill;
  logic                  push, pop, head_dir, pend_q, pend_dir_q;

  assign req_ready = (fill != FILL_FULL);
  assign push      = req_valid & req_ready;
  assign pop       = (state == IDLE) & ~pend_q & (fill != '0);
  assign head_dir  = fifo_dir[rd_ptr];
  assign refuse    = pop & ~room_for(head_dir, no_cars);
  assign start     = pend_q;
  assign start_dir = pend_dir_q;

  // Direction FIFO: storage, wrap-around pointers and fill level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_dir <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
    end else begin
      if (push) begin
        fifo_dir[wr_ptr] <= req_dir;
        wr_ptr           <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fill <= fill + 1'b1;
      end else if (pop && !push) begin
        fill <= fill - 1'b1;
      end
    end
  end

  // A popped command that passed the limit check launches on the following edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q     <= 1'b0;
      pend_dir_q <= 1'b0;
    end else begin
      pend_q     <= pop & room_for(head_dir, no_cars);
      pend_dir_q <= head_dir;
    end
  end
`else
  logic accept;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign start     = accept & room_for(req_dir, no_cars);
  assign refuse    = accept & ~room_for(req_dir, no_cars);
  assign start_dir = req_dir;
`endif

  assign busy = (state != IDLE);

  // State, phase counter, latched direction and every visible output are flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      dir_q    <= 1'b0;
      A        <= 1'b0;
      B        <= 1'b0;
      done     <= 1'b0;
      reject   <= 1'b0;
      no_cars  <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      dir_q    <= dir_nxt;
      A        <= a_nxt;
      B        <= b_nxt;
      done     <= done_nxt;
      reject   <= refuse;
      no_cars  <= no_cars_nxt;
    end
  end

  // Phase sequencing, count update on completion, and the A/B pattern of the next state.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    dir_nxt      = dir_q;
    done_nxt     = 1'b0;
    no_cars_nxt  = no_cars;
    a_nxt        = 1'b0;
    b_nxt        = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = PH1;
          hold_cnt_nxt = '0;
          dir_nxt      = start_dir;
        end
      end
      default: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_cnt_nxt = '0;
          case (state)
            PH1:     state_nxt = PH2;
            PH2:     state_nxt = PH3;
            PH3:     state_nxt = GAP;
            default: begin
              state_nxt   = IDLE;
              done_nxt    = 1'b1;
              no_cars_nxt = dir_q ? no_cars + 1'b1 : no_cars - 1'b1;
            end
          endcase
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
    endcase

    // Enter walks 10->11->01, exit walks 01->11->10; both fall back to 00.
    case (state_nxt)
      PH1:     {a_nxt, b_nxt} = dir_nxt ? 2'b10 : 2'b01;
      PH2:     {a_nxt, b_nxt} = 2'b11;
      PH3:     {a_nxt, b_nxt} = dir_nxt ? 2'b01 : 2'b10;
      default: {a_nxt, b_nxt} = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_car_sensor_driver.sv
// tb_car_sensor_driver: directed bench for car_sensor_driver with hand-written A/B sequences.
// Latency: sequences checked cycle by cycle from the accept (or pop) edge through the done pulse.
// Backpressure: holds req_valid through a full direction FIFO when CMD_FIFO_EN is defined.
module tb_car_sensor_driver;

  localparam int H = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_dir;
  logic       req_ready;
  logic       A;
  logic       B;
  logic       busy;
  logic       done;
  logic       reject;
  logic [3:0] no_cars;

  int vectors     = 0;
  int miscompares = 0;
  int exp_cars    = 0;

  logic [1:0] enter_ab [8];
  logic [1:0] exit_ab  [8];

  always #5 clk = ~clk;

  car_sensor_driver #(
    .HOLD_CYCLES(H),
    .CNT_W      (4),
    .MAX_CARS   (15),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_dir  (req_dir),
    .req_ready(req_ready),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .reject   (reject),
    .no_cars  (no_cars)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one command for one edge; returns just after the edge where reject would show.
  task automatic send(input logic dir);
    req_valid = 1'b1;
    req_dir   = dir;
    tick;
    req_valid = 1'b0;
`ifdef CMD_FIFO_EN
    tick;
`endif
  endtask

  // One full accepted sequence, checked phase by phase, then the done pulse and new count.
  task automatic run_seq(input logic dir);
    send(dir);
`ifdef CMD_FIFO_EN
    tick;
`endif
    for (int i = 0; i < 8; i++) begin
      chk(dir ? "enter_ab" : "exit_ab", {A, B}, dir ? enter_ab[i] : exit_ab[i]);
      chk("seq_busy", busy, 1);
      chk("seq_done_low", done, 0);
      req_dir = ~dir;
      tick;
    end
    exp_cars = dir ? exp_cars + 1 : exp_cars - 1;
    chk("done_pulse", done, 1);
    chk("no_cars_after", no_cars, exp_cars);
    chk("busy_after", busy, 0);
    chk("ready_after", req_ready, 1);
    chk("ab_after", {A, B}, 2'b00);
    tick;
    chk("done_one_cycle", done, 0);
  endtask

  // Watchdog: every wait below is bounded, this only guards against a stuck simulator.
  initial begin
    #1000000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  initial begin
    enter_ab = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
    exit_ab  = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_dir   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", A, 0);
    chk("rst_b", B, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_reject", reject, 0);
    chk("rst_no_cars", no_cars, 0);
    chk("rst_ready", req_ready, 1);
    reset = 1'b0;
    tick;

    // One enter, then enter, exit: count 1 -> 2 -> 1.
    run_seq(1'b1);
    run_seq(1'b1);
    run_seq(1'b0);

    // Drain to zero, then an exit must be refused.
    run_seq(1'b0);
    send(1'b0);
    chk("rej_exit_pulse", reject, 1);
    chk("rej_exit_ab", {A, B}, 2'b00);
    chk("rej_exit_cars", no_cars, 0);
    chk("rej_exit_busy", busy, 0);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("rej_exit_low", reject, 0);
      chk("rej_exit_nodone", done, 0);
      chk("rej_exit_ab_hold", {A, B}, 2'b00);
    end

    // Fill the lot, refuse the 16th car, then let one out.
    for (int n = 0; n < 15; n++) begin
      run_seq(1'b1);
    end
    chk("full_cars", no_cars, 15);
    send(1'b1);
    chk("rej_full_pulse", reject, 1);
    chk("rej_full_cars", no_cars, 15);
    chk("rej_full_ab", {A, B}, 2'b00);
    chk("rej_full_busy", busy, 0);
    tick;
    chk("rej_full_low", reject, 0);
    chk("rej_full_nodone", done, 0);
    run_seq(1'b0);
    chk("after_full_exit", no_cars, 14);

    // Reset in the middle of PH2 clears everything immediately.
    send(1'b1);
`ifdef CMD_FIFO_EN
    tick;
`endif
    tick;
    tick;
    chk("ph2_ab", {A, B}, 2'b11);
    chk("ph2_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("midrst_ab", {A, B}, 2'b00);
    chk("midrst_busy", busy, 0);
    chk("midrst_cars", no_cars, 0);
    chk("midrst_done", done, 0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    exp_cars = 0;
    tick;
    run_seq(1'b1);

`ifdef CMD_FIFO_EN
    begin
      int pushed    = 0;
      int dones     = 0;
      int last_done = -1;
      int saw_full  = 0;
      logic rdy;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      for (int c = 0; c < 200 && dones < 6; c++) begin
        rdy       = req_ready;
        req_valid = (pushed < 6);
        req_dir   = 1'b1;
        if (!rdy) saw_full = 1;
        tick;
        if (req_valid && rdy) pushed++;
        if (done) begin
          dones++;
          if (last_done >= 0) chk("fifo_gap", c - last_done, 4 * H + 2);
          last_done = c;
        end
      end
      req_valid = 1'b0;
      chk("fifo_ready_dropped", saw_full, 1);
      chk("fifo_pushed", pushed, 6);
      chk("fifo_dones", dones, 6);
      chk("fifo_no_cars", no_cars, 6);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
